tap_keypad_scanner: RTL and testbench
=====================================

# tap_keypad_scanner

Scans a 3x3 mole-hole keypad matrix, debounces each key, and emits one-cycle `tap` pulses to `game_logic`: the producing end of the `tap[8:0]` interface that `game_logic` consumes. It replaces the FPGA-board button/switch tap source for the real game cabinet. It sits beside `time_counter` and `music` in the top level, clocked by the board clock.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `SCAN_HZ`, 1000, row-switch rate; dwell per row `DIV = CLK_HZ/SCAN_HZ` cycles (integer, ≥2).
- `DEBOUNCE_SAMPLES`, 4, consecutive equal samples needed to change a key's stable state (≥1).
- `clk` in 1: system clock.
- `clr` in 1: reset; synchronous, active-high.
- `enable` in 1: high during a game; low suppresses `tap` only.
- `col_n` in 3: column sense, active-low (board pull-ups); bit c = column c.
- `row_n` out 3: row drive, active-low, exactly one bit low at all times.
- `tap` out 9: one-cycle press pulses; bit `row*3+col`.
- `held` out 9: debounced stable key state, 1 = pressed.

## Operation
- Prescaler `div_cnt` counts 0..DIV-1 and wraps. `sample` = (`div_cnt == DIV-1`).
- Row FSM states ROW0 → ROW1 → ROW2 → ROW0, advancing the cycle after `sample`. `row_n` is 3'b110, 3'b101 or 3'b011 respectively.
- On `sample`, for the active row r and each column c, raw = `~col_n[c]` is fed to the debouncer of key `r*3+c`. Keys in other rows receive no sample.
- Debouncer per key: keeps a stable bit and a count.
  - Sample equals stable: count ← 0.
  - Sample differs: count increments. When it reaches `DEBOUNCE_SAMPLES`, stable ← sample and count ← 0.
- `held` = stable bits.
- `tap[k]` = 1 for exactly the one cycle after stable k goes 0→1, and only if `enable` is high in that cycle. A 1→0 change never pulses.
- Keys are independent. Several `tap` bits may assert in the same cycle; within one scan this happens only for keys in the same row.
- No anti-ghosting; there are no diodes on the board matrix.
- `enable` low: scanning and debouncing continue and `held` tracks. Presses that complete while `enable` is low are lost; they are not replayed when `enable` rises.
- A key held continuously produces one pulse. It must go stable-released and then stable-pressed to produce the next.

## Timing
- Reset values (cycle after `clr` high): `div_cnt`=0, state ROW0, `row_n`=3'b110, all counts 0, `held`=0, `tap`=0.
- `clr` mid-debounce or mid-scan discards all partial counts. A key still pressed after reset re-debounces and then pulses again.
- `tap`, `held` and `row_n` are all registered outputs.
- Each key is sampled once every 3·DIV cycles.
- Press-to-`tap` latency is between (DEBOUNCE_SAMPLES−1)·3·DIV+1 and DEBOUNCE_SAMPLES·3·DIV+1 cycles, depending on scan phase.
- `held` rises in the same cycle that `tap` rises.
- Row drive changes one cycle after `sample`, which gives DIV−1 settling cycles before the next sample.

## Structure
- `game_pkg`: `NUM_HOLES`=9, `ROWS`=3, `COLS`=3, and the hole-index rule `row*COLS+col`. `game_logic` shares this package.
- Sub-module `key_debounce` (parameter `DEBOUNCE_SAMPLES`; ports `clk`, `clr`, `sample_en`, `raw`, `stable`, `rise`), instantiated 9 times.
- The top level holds the prescaler, the row FSM, the sample steering and the `enable` gating.

## Test plan
All scenarios use `CLK_HZ`=12, `SCAN_HZ`=3 (DIV=4) and `DEBOUNCE_SAMPLES`=2.
- Reset: hold `clr` 3 cycles → `row_n`=3'b110, `tap`=0, `held`=0. After release, `row_n` walks 110→101→011→110 every 4 cycles.
- Single press: `enable`=1, key 4 (row1, col1) held 40 cycles → exactly one cycle with `tap`=9'h010. `held[4]`=1 from that cycle on; latency within 13..25 cycles.
- Bounce: key 4 toggles every 12 cycles (one sample pressed, one released) → `tap` stays 0 and `held` stays 0.
- Same-row simultaneous press: keys 6 and 8 pressed together → a single cycle with `tap`=9'h140.
- Enable gating: key 0 press completes with `enable`=0 → `tap`=0 and `held[0]`=1. Raising `enable` while the key is still held gives no pulse. Release, then press again with `enable`=1 → `tap`=9'h001 once.
- Reset mid-debounce: key 2 has one pressed sample, then `clr` → count cleared. Continued press produces `tap`=9'h004 only after 2 fresh samples.

Source files
------------

// File: rtl/tap_keypad_scanner_pkg.sv
// Shared keypad/game constants and helpers.
// Used by the scanner, its bus interface and game_logic.
package tap_keypad_scanner_pkg;

    localparam int NUM_HOLES = 9;
    localparam int ROWS      = 3;
    localparam int COLS      = 3;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2
    } row_state_e;

    // Hole numbering shared with game_logic.
    function automatic int hole_idx(input int row, input int col);
        return row * COLS + col;
    endfunction

    // Active-low drive pattern for the selected row.
    function automatic logic [ROWS-1:0] row_drive(input row_state_e s);
        logic [ROWS-1:0] v;
        unique case (s)
            ROW0:    v = 3'b110;
            ROW1:    v = 3'b101;
            ROW2:    v = 3'b011;
            default: v = 3'b110;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tap_keypad_scanner_if.sv
// Keypad matrix + tap bus between scanner and game_logic.
// master: scanner (drives rows, tap, held); slave: board/consumer.
interface tap_keypad_scanner_if;
    import tap_keypad_scanner_pkg::*;

    logic                 enable;
    logic [COLS-1:0]      col_n;
    logic [ROWS-1:0]      row_n;
    logic [NUM_HOLES-1:0] tap;
    logic [NUM_HOLES-1:0] held;

    modport master (
        input  enable,
        input  col_n,
        output row_n,
        output tap,
        output held
    );

    modport slave (
        output enable,
        output col_n,
        input  row_n,
        input  tap,
        input  held
    );

endinterface

// File: rtl/tap_keypad_scanner_key_debounce.sv
// Per-key sample-count debouncer.
// Ports: i_clk, i_clr (sync, active-high), i_sample_en, i_raw,
//        o_stable (debounced state), o_rise (strobe: stable about to go 0->1).
module key_debounce #(
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_sample_en,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int CW =
        (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_SAMPLES - 1);

    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          w_differs;
    logic          w_flip;

    assign w_differs = i_sample_en && (i_raw != r_stable);
    // Count holds differing samples seen so far; this one is the Nth.
    assign w_flip    = w_differs && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (i_sample_en) begin
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_stable <= i_raw;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_flip && i_raw;

endmodule

// File: rtl/tap_keypad_scanner.sv
// 3x3 keypad matrix scanner: prescaler, row FSM, per-key debounce, tap pulses.
// Ports: i_clk, i_clr (sync, active-high), bus (master: enable, col_n in;
//        row_n, tap, held out -- all outputs registered).
module tap_keypad_scanner
    import tap_keypad_scanner_pkg::*;
#(
    parameter int CLK_HZ           = 100_000_000,
    parameter int SCAN_HZ          = 1000,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_clr,
    tap_keypad_scanner_if.master  bus
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0]        r_div_cnt;
    logic                 w_sample;
    row_state_e           r_state;
    row_state_e           w_state_nxt;
    logic [ROWS-1:0]      r_row_n;
    logic [ROWS-1:0]      w_row_n_nxt;
    logic [NUM_HOLES-1:0] w_sample_en;
    logic [NUM_HOLES-1:0] w_raw;
    logic [NUM_HOLES-1:0] w_stable;
    logic [NUM_HOLES-1:0] w_rise;
    logic [NUM_HOLES-1:0] r_tap;

    // Prescaler: one sample strobe per row dwell.
    assign w_sample = (r_div_cnt == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_div_cnt <= '0;
        end else if (w_sample) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Row FSM: state register.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= ROW0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Row FSM: next state, advancing after the sample cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (w_sample) begin
            unique case (r_state)
                ROW0:    w_state_nxt = ROW1;
                ROW1:    w_state_nxt = ROW2;
                ROW2:    w_state_nxt = ROW0;
                default: w_state_nxt = ROW0;
            endcase
        end
    end

    // Row FSM: output decode from next state so row_n is a flop.
    always_comb begin
        w_row_n_nxt = row_drive(w_state_nxt);
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_row_n <= 3'b110;
        end else begin
            r_row_n <= w_row_n_nxt;
        end
    end

    // Sample steering: only keys on the driven row see the strobe.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int K = hole_idx(gr, gc);
            localparam logic [1:0] RI = 2'(gr);

            assign w_sample_en[K] = w_sample && (r_state == RI);
            assign w_raw[K]       = ~bus.col_n[gc];

            key_debounce #(
                .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
            ) u_db (
                .i_clk       (i_clk),
                .i_clr       (i_clr),
                .i_sample_en (w_sample_en[K]),
                .i_raw       (w_raw[K]),
                .o_stable    (w_stable[K]),
                .o_rise      (w_rise[K])
            );
        end
    end

    // Registered alongside the stable flop, so tap and held rise together.
    // Presses completing with enable low are dropped, not deferred.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_tap <= '0;
        end else begin
            r_tap <= w_rise & {NUM_HOLES{bus.enable}};
        end
    end

    assign bus.row_n = r_row_n;
    assign bus.tap   = r_tap;
    assign bus.held  = w_stable;

endmodule

// File: tb/tb_tap_keypad_scanner.sv
// Bench for tap_keypad_scanner: matrix model, reference model, scoreboard.
// Directed scenarios followed by randomized press/enable/clr traffic.
module tb_tap_keypad_scanner;
    import tap_keypad_scanner_pkg::*;

    localparam int CLK_HZ  = 12;
    localparam int SCAN_HZ = 3;
    localparam int NDB     = 2;
    localparam int DIV     = CLK_HZ / SCAN_HZ;

    typedef struct {
        int         cyc;
        logic [8:0] tap;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       enable = 1'b0;
    logic [8:0] pressed = '0;
    logic [2:0] w_col;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t = 0;
    int reset_cyc = 0;
    logic [8:0] m_held = '0;
    int m_cnt [9];
    exp_t q [$];

    int tap_count = 0;
    logic [8:0] last_tap = '0;
    int last_tap_cyc = 0;

    always #5 clk = ~clk;

    tap_keypad_scanner_if bus ();

    tap_keypad_scanner #(
        .CLK_HZ           (CLK_HZ),
        .SCAN_HZ          (SCAN_HZ),
        .DEBOUNCE_SAMPLES (NDB)
    ) dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (bus.master)
    );

    // Board matrix: a pressed key on a driven row pulls its column low.
    always_comb begin
        w_col = 3'b111;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                if (!bus.row_n[r] && pressed[r*3+c])
                    w_col[c] = 1'b0;
    end

    assign bus.col_n  = w_col;
    assign bus.enable = enable;

    // Reference model: key k is sampled once per 3*DIV cycles, in the
    // last cycle of its row's dwell; NDB differing samples flip it.
    always @(posedge clk) begin
        logic [8:0] tap_e;
        exp_t e;
        cyc++;
        if (clr) begin
            t = 0;
            m_held = '0;
            for (int k = 0; k < 9; k++) m_cnt[k] = 0;
            reset_cyc = cyc;
            q.delete();
        end else begin
            tap_e = '0;
            if (t % DIV == DIV - 1) begin
                for (int c = 0; c < 3; c++) begin
                    int k;
                    k = ((t / DIV) % 3) * 3 + c;
                    if (pressed[k] == m_held[k]) begin
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k]++;
                        if (m_cnt[k] == NDB) begin
                            m_held[k] = pressed[k];
                            m_cnt[k] = 0;
                            if (pressed[k] && enable) tap_e[k] = 1'b1;
                        end
                    end
                end
            end
            t++;
            if (tap_e != 0) begin
                e.cyc = cyc;
                e.tap = tap_e;
                q.push_back(e);
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [2:0] er;
        er = 3'b111;
        er[(t / DIV) % 3] = 1'b0;
        tests++;
        if (bus.row_n !== er) begin
            fails++;
            $display("FAIL row_n cyc=%0d got %b want %b", cyc, bus.row_n, er);
        end
        tests++;
        if (bus.held !== m_held) begin
            fails++;
            $display("FAIL held cyc=%0d got %h want %h", cyc, bus.held, m_held);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL tap_missed cyc=%0d got none want %h", q[0].cyc, q[0].tap);
            void'(q.pop_front());
        end
        if (bus.tap !== 9'h000) begin
            tests++;
            tap_count++;
            last_tap = bus.tap;
            last_tap_cyc = cyc;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                fails++;
                $display("FAIL tap_unexpected cyc=%0d got %h want 000", cyc, bus.tap);
            end else begin
                if (bus.tap !== q[0].tap) begin
                    fails++;
                    $display("FAIL tap_value cyc=%0d got %h want %h", cyc, bus.tap, q[0].tap);
                end
                void'(q.pop_front());
            end
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            tests++;
            fails++;
            $display("FAIL tap_absent cyc=%0d got 000 want %h", cyc, q[0].tap);
            void'(q.pop_front());
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        clr = 1'b1;
        wait_cyc(n);
        clr = 1'b0;
        tap_count = 0;
    endtask

    initial begin
        int press_cyc;
        int lat;

        // Reset and row walk.
        pressed = 9'h1ff;
        wait_cyc(3);
        chk("rst_row_n", int'(bus.row_n), 6);
        chk("rst_tap", int'(bus.tap), 0);
        chk("rst_held", int'(bus.held), 0);
        pressed = '0;
        clr = 1'b0;
        chk("walk0", int'(bus.row_n), 6);
        wait_cyc(4);
        chk("walk1", int'(bus.row_n), 5);
        wait_cyc(4);
        chk("walk2", int'(bus.row_n), 3);
        wait_cyc(4);
        chk("walk3", int'(bus.row_n), 6);

        // Single press of key 4.
        do_reset(3);
        enable = 1'b1;
        wait_cyc(5);
        pressed = 9'h010;
        press_cyc = cyc;
        wait_cyc(40);
        lat = last_tap_cyc - press_cyc;
        chk("single_count", tap_count, 1);
        chk("single_value", int'(last_tap), 'h010);
        chk("single_lat_ok", int'(lat >= 13 && lat <= 25), 1);
        chk("single_held4", int'(bus.held[4]), 1);

        // Bounce: one pressed, one released sample per 12-cycle window.
        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 9'h010 : 9'h000;
            wait_cyc(12);
        end
        chk("bounce_count", tap_count, 0);
        chk("bounce_held", int'(bus.held), 0);
        pressed = '0;

        // Same-row simultaneous press.
        do_reset(3);
        pressed = 9'h140;
        wait_cyc(40);
        chk("row_count", tap_count, 1);
        chk("row_value", int'(last_tap), 'h140);
        pressed = '0;

        // Enable gating.
        do_reset(3);
        enable = 1'b0;
        pressed = 9'h001;
        wait_cyc(30);
        chk("gate_held0", int'(bus.held[0]), 1);
        chk("gate_off_count", tap_count, 0);
        enable = 1'b1;
        wait_cyc(30);
        chk("gate_rise_count", tap_count, 0);
        pressed = '0;
        wait_cyc(30);
        chk("gate_release", int'(bus.held[0]), 0);
        pressed = 9'h001;
        wait_cyc(30);
        chk("gate_on_count", tap_count, 1);
        chk("gate_on_value", int'(last_tap), 'h001);
        pressed = '0;

        // Reset mid-debounce.
        do_reset(3);
        pressed = 9'h004;
        wait_cyc(6);
        do_reset(1);
        wait_cyc(30);
        chk("mid_count", tap_count, 1);
        chk("mid_value", int'(last_tap), 'h004);
        chk("mid_lat", last_tap_cyc - reset_cyc, 16);
        pressed = '0;

        // Randomized traffic checked by the scoreboard.
        do_reset(2);
        for (int i = 0; i < 60; i++) begin
            pressed = 9'($urandom);
            if ($urandom_range(0, 3) == 0) pressed = '0;
            enable = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) do_reset(1);
            wait_cyc($urandom_range(1, 30));
        end

        pressed = '0;
        wait_cyc(30);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
